// File: rtl/s3_writeback_pkg.sv
// Shared opcode header: RV32I opcodes, funct3 codes, the NOP encoding,
// the tohost CSR address and the address-region nibbles used by the core.
package s3_writeback_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
  localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;

  // Load funct3 codes
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  // CSR funct3 codes
  localparam logic [2:0] FNC_CSRRW  = 3'b001;
  localparam logic [2:0] FNC_CSRRWI = 3'b101;

  // addi x0,x0,0 -- injected on reset and flush
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // The only CSR implemented in the writeback stage
  localparam logic [11:0] CSR_TOHOST = 12'h51E;

  // Address-region nibbles (addr[31:28])
  localparam logic [3:0] REG_DMEM_A = 4'b0001;
  localparam logic [3:0] REG_DMEM_B = 4'b0011;
  localparam logic [3:0] REG_BIOS   = 4'b0100;
  localparam logic [3:0] REG_IO     = 4'b1000;

endpackage

// File: rtl/s3_writeback_load_align.sv
// Load data alignment: picks the addressed byte/half out of a 32-bit word
// and sign- or zero-extends it according to the load funct3.
module s3_writeback_load_align
  import s3_writeback_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Extract the addressed byte and half; the half ignores addr[0]
  always_comb begin
    sel_byte = word[7:0];
    case (addr)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = addr[1] ? word[31:16] : word[15:0];
  end

  // Extend according to load width; LW and undefined codes pass the word
  always_comb begin
    result = word;
    case (funct3)
      FNC_LB:  result = {{24{sel_byte[7]}}, sel_byte};
      FNC_LBU: result = {24'd0, sel_byte};
      FNC_LH:  result = {{16{sel_half[15]}}, sel_half};
      FNC_LHU: result = {16'd0, sel_half};
      FNC_LW:  result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/s3_writeback.sv
// Stage-3 writeback: pipeline registers, load alignment, register-file write
// port, the tohost CSR and the cycle/instruction counters.
module s3_writeback
  import s3_writeback_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush_s2,
  input  logic [31:0]      instruction_s2,
  input  logic [31:0]      alu_s2,
  input  logic [31:0]      pc_s2,
  input  logic [31:0]      csr_wdata_s2,
  input  logic [31:0]      dmem_dout,
  input  logic [31:0]      bios_dout,
  input  logic [31:0]      io_dout,
  input  logic             counter_rst,
  output logic [31:0]      instruction_s3,
  output logic [31:0]      wb_data,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [31:0]      csr_tohost,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0] inst_s3;
  logic [31:0] alu_s3;
  logic [31:0] pc_s3;
  logic [31:0] csrw_s3;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        csr_write;
  logic [31:0] csr_next;
  logic [31:0] load_raw;
  logic [31:0] load_data;

  assign opcode = inst_s3[6:0];
  assign funct3 = inst_s3[14:12];
  assign rd     = inst_s3[11:7];

  // Decode a tohost write carried by the instruction currently in stage 3
  always_comb begin
    csr_write = 1'b0;
    csr_next  = csrw_s3;
    if (opcode == OPC_CSR && inst_s3[31:20] == CSR_TOHOST) begin
      if (funct3 == FNC_CSRRW) begin
        csr_write = 1'b1;
        csr_next  = csrw_s3;
      end else if (funct3 == FNC_CSRRWI) begin
        csr_write = 1'b1;
        csr_next  = {27'd0, inst_s3[19:15]};
      end
    end
  end

  // Pipeline registers, tohost and counters; CSR and inst_cnt update only when stage 3 advances
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_s3    <= NOP_INST;
      alu_s3     <= 32'd0;
      pc_s3      <= 32'd0;
      csrw_s3    <= 32'd0;
      csr_tohost <= 32'd0;
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (!stall) begin
        inst_s3 <= flush_s2 ? NOP_INST : instruction_s2;
        alu_s3  <= alu_s2;
        pc_s3   <= pc_s2;
        csrw_s3 <= csr_wdata_s2;
        if (csr_write) begin
          csr_tohost <= csr_next;
        end
        if (inst_s3 != NOP_INST) begin
          inst_cnt <= inst_cnt + CNT_ONE;
        end
      end
      if (counter_rst) begin
        cycle_cnt <= '0;
        inst_cnt  <= '0;
      end
    end
  end

  // Select the memory that backs the load address region
  always_comb begin
    load_raw = 32'd0;
    case (alu_s3[31:28])
      REG_DMEM_A, REG_DMEM_B: load_raw = dmem_dout;
      REG_BIOS:               load_raw = bios_dout;
      REG_IO:                 load_raw = io_dout;
      default:                load_raw = 32'd0;
    endcase
  end

  s3_writeback_load_align u_load_align (
    .word   (load_raw),
    .addr   (alu_s3[1:0]),
    .funct3 (funct3),
    .result (load_data)
  );

  // Writeback value and register-file write enable by opcode
  always_comb begin
    wb_data = 32'd0;
    rf_we   = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        wb_data = load_data;
        rf_we   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        wb_data = pc_s3 + 32'd4;
        rf_we   = 1'b1;
      end
      OPC_ARI_R, OPC_ARI_I, OPC_LUI, OPC_AUIPC: begin
        wb_data = alu_s3;
        rf_we   = 1'b1;
      end
      default: begin
        wb_data = 32'd0;
        rf_we   = 1'b0;
      end
    endcase
    if (rd == 5'd0) begin
      rf_we = 1'b0;
    end
  end

  assign instruction_s3 = inst_s3;
  assign rf_wa          = rd;

endmodule
